// File: rtl/compressor_frame_sequencer.sv
// Loads up to NUM_SRC operand rows into a buffer that drives the compressor, waits LAT
// settle cycles, then presents the captured compressor result on a valid/ready stream.
module compressor_frame_sequencer #(
    parameter int NUM_SRC   = 23,
    parameter int WIDTH     = 23,
    parameter int DST_WIDTH = 29,
    parameter int LAT       = 0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [WIDTH-1:0]           in_data_i,
    input  logic                       in_last_i,
    output logic [NUM_SRC*WIDTH-1:0]   comp_src_o,
    input  logic [DST_WIDTH-1:0]       comp_dst_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [DST_WIDTH-1:0]       out_data_o,
    output logic                       frame_err_o,
    output logic                       busy_o,
    output logic [15:0]                frame_cnt_o
);

    localparam int CNT_W = $clog2(NUM_SRC + 1);
    localparam int LAT_W = 4;

    // state  | meaning
    // S_LOAD | accepting rows into the buffer
    // S_WAIT | buffer frozen, lat_cnt counts down while the compressor settles
    // S_OUT  | result held on out_data until the output handshake
    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [NUM_SRC*WIDTH-1:0]   rows_q, rows_d;
    logic [CNT_W-1:0]           row_cnt_q, row_cnt_d;
    logic [LAT_W-1:0]           lat_cnt_q, lat_cnt_d;
    logic [DST_WIDTH-1:0]       out_data_q, out_data_d;
    logic                       frame_err_q, frame_err_d;
    logic [15:0]                frame_cnt_q, frame_cnt_d;
    logic                       last_row;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_LOAD;
            rows_q      <= '0;
            row_cnt_q   <= '0;
            lat_cnt_q   <= '0;
            out_data_q  <= '0;
            frame_err_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rows_q      <= rows_d;
            row_cnt_q   <= row_cnt_d;
            lat_cnt_q   <= lat_cnt_d;
            out_data_q  <= out_data_d;
            frame_err_q <= frame_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign last_row = (row_cnt_q == CNT_W'(NUM_SRC - 1));

    always_comb begin
        state_d     = state_q;
        rows_d      = rows_q;
        row_cnt_d   = row_cnt_q;
        lat_cnt_d   = lat_cnt_q;
        out_data_d  = out_data_q;
        frame_err_d = 1'b0;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            S_LOAD: begin
                if (in_valid_i) begin
                    for (int k = 0; k < NUM_SRC; k++) begin
                        if (row_cnt_q == CNT_W'(k)) begin
                            rows_d[k*WIDTH +: WIDTH] = in_data_i;
                        end
                    end
                    row_cnt_d = row_cnt_q + CNT_W'(1);
                    if (in_last_i || last_row) begin
                        state_d   = S_WAIT;
                        lat_cnt_d = LAT_W'(LAT);
                    end
                    frame_err_d = last_row && !in_last_i;
                end
            end
            S_WAIT: begin
                if (lat_cnt_q == '0) begin
                    out_data_d = comp_dst_i;
                    state_d    = S_OUT;
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end
            end
            S_OUT: begin
                // Clearing the buffer here is what makes short frames see zero upper rows.
                if (out_ready_i) begin
                    state_d     = S_LOAD;
                    rows_d      = '0;
                    row_cnt_d   = '0;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_comb begin
        in_ready_o  = (state_q == S_LOAD);
        out_valid_o = (state_q == S_OUT);
        busy_o      = (state_q != S_LOAD);
    end

    assign comp_src_o  = rows_q;
    assign out_data_o  = out_data_q;
    assign frame_err_o = frame_err_q;
    assign frame_cnt_o = frame_cnt_q;

endmodule
